alu_arith: RTL and testbench

- 32-bit integer arithmetic/compare unit for the datapath execute stage.
- Performs ADD, SUB and six signed set-on-compare ops selected by a 4-bit control code.
- Primary result and flags are registered: one-cycle latency.
- Internal compare/mux nodes are exported as debug taps.

---
 rtl/alu_arith.sv | 159 +++++++++++++++
 tb/tb_alu_arith.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_arith.sv
// alu_arith: 32-bit add/sub/signed-compare unit, registered result (1 cycle).
// Ports: clk, rst_n (sync, active-low), in1/in2 operands, crtlSig op select,
//   out/cout/overflow registered; adder_out, diff, s*_out, logical_32_out,
//   mux_0..4_out are combinational debug taps, live only when ALU_DEBUG_TAPS_EN
//   is defined (tied to 0 otherwise).
module alu_arith #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       crtlSig,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] adder_out,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] seq_out,
  output logic [WIDTH-1:0] sne_out,
  output logic [WIDTH-1:0] slt_out,
  output logic [WIDTH-1:0] sgt_out,
  output logic [WIDTH-1:0] sle_out,
  output logic [WIDTH-1:0] sge_out,
  output logic [WIDTH-1:0] logical_32_out,
  output logic [WIDTH-1:0] mux_0_out,
  output logic [WIDTH-1:0] mux_1_out,
  output logic [WIDTH-1:0] mux_2_out,
  output logic [WIDTH-1:0] mux_3_out,
  output logic [WIDTH-1:0] mux_4_out
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sub;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             seq;
  logic             sne;
  logic             slt;
  logic             sgt;
  logic             sle;
  logic             sge;
  logic             mux_0;
  logic             mux_1;
  logic             mux_2;
  logic             mux_3;
  logic             mux_4;
  logic             is_add;
  logic             is_sub;
  logic             is_cmp;
  logic [WIDTH-1:0] out_nxt;
  logic             cout_nxt;
  logic             ovf_nxt;

  assign sum = {1'b0, in1} + {1'b0, in2};
  // Subtract as in1 + ~in2 + 1 so the carry-out means "no borrow".
  assign sub = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ovf = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
  assign sub_ovf = (in1[MSB] != in2[MSB]) && (sub[MSB] != in1[MSB]);

  // Signed less-than: sign of the difference, corrected on overflow.
  assign lt = sub[MSB] ^ sub_ovf;
  assign eq = (in1 == in2);
  assign gt = !lt && !eq;

  assign seq = eq;
  assign sne = !eq;
  assign slt = lt;
  assign sgt = gt;
  assign sle = lt | eq;
  assign sge = !lt;

  assign mux_0 = crtlSig[3] ? sne : seq;
  assign mux_1 = crtlSig[3] ? sle : slt;
  assign mux_2 = crtlSig[3] ? sge : sgt;
  assign mux_3 = crtlSig[2] ? mux_1 : mux_2;
  assign mux_4 = (crtlSig[2:1] == 2'b00) ? mux_0 : mux_3;

  assign is_add = (crtlSig == 4'b0000);
  assign is_sub = (crtlSig == 4'b1000);
  assign is_cmp = crtlSig[0] && (crtlSig[2:1] != 2'b11);

  always_comb begin
    out_nxt  = '0;
    cout_nxt = 1'b0;
    ovf_nxt  = 1'b0;
    unique case (1'b1)
      is_add: begin
        out_nxt  = sum[MSB:0];
        cout_nxt = sum[WIDTH];
        ovf_nxt  = add_ovf;
      end
      is_sub: begin
        out_nxt  = sub[MSB:0];
        cout_nxt = sub[WIDTH];
        ovf_nxt  = sub_ovf;
      end
      is_cmp: begin
        out_nxt = {{(WIDTH-1){1'b0}}, mux_4};
      end
      default: begin
        out_nxt  = '0;
        cout_nxt = 1'b0;
        ovf_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      out      <= out_nxt;
      cout     <= cout_nxt;
      overflow <= ovf_nxt;
    end
  end

`ifdef ALU_DEBUG_TAPS_EN
  assign adder_out      = sum[MSB:0];
  assign diff           = sub[MSB:0];
  assign seq_out        = {{(WIDTH-1){1'b0}}, seq};
  assign sne_out        = {{(WIDTH-1){1'b0}}, sne};
  assign slt_out        = {{(WIDTH-1){1'b0}}, slt};
  assign sgt_out        = {{(WIDTH-1){1'b0}}, sgt};
  assign sle_out        = {{(WIDTH-1){1'b0}}, sle};
  assign sge_out        = {{(WIDTH-1){1'b0}}, sge};
  assign mux_0_out      = {{(WIDTH-1){1'b0}}, mux_0};
  assign mux_1_out      = {{(WIDTH-1){1'b0}}, mux_1};
  assign mux_2_out      = {{(WIDTH-1){1'b0}}, mux_2};
  assign mux_3_out      = {{(WIDTH-1){1'b0}}, mux_3};
  assign mux_4_out      = {{(WIDTH-1){1'b0}}, mux_4};
  assign logical_32_out = {{(WIDTH-1){1'b0}}, mux_4};
`else
  assign adder_out      = '0;
  assign diff           = '0;
  assign seq_out        = '0;
  assign sne_out        = '0;
  assign slt_out        = '0;
  assign sgt_out        = '0;
  assign sle_out        = '0;
  assign sge_out        = '0;
  assign mux_0_out      = '0;
  assign mux_1_out      = '0;
  assign mux_2_out      = '0;
  assign mux_3_out      = '0;
  assign mux_4_out      = '0;
  assign logical_32_out = '0;
`endif

endmodule

// File: tb/tb_alu_arith.sv
// tb_alu_arith: directed vectors for alu_arith with hand-computed results.
// Covers reset, compare sweep, signed compares, carry/overflow, illegal ops, taps.
module tb_alu_arith;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  crtlSig;
  logic [31:0] out;
  logic        cout;
  logic        overflow;
  logic [31:0] adder_out;
  logic [31:0] diff;
  logic [31:0] seq_out;
  logic [31:0] sne_out;
  logic [31:0] slt_out;
  logic [31:0] sgt_out;
  logic [31:0] sle_out;
  logic [31:0] sge_out;
  logic [31:0] logical_32_out;
  logic [31:0] mux_0_out;
  logic [31:0] mux_1_out;
  logic [31:0] mux_2_out;
  logic [31:0] mux_3_out;
  logic [31:0] mux_4_out;

  int checks;
  int failures;

  alu_arith dut (
    .clk(clk),
    .rst_n(rst_n),
    .in1(in1),
    .in2(in2),
    .crtlSig(crtlSig),
    .out(out),
    .cout(cout),
    .overflow(overflow),
    .adder_out(adder_out),
    .diff(diff),
    .seq_out(seq_out),
    .sne_out(sne_out),
    .slt_out(slt_out),
    .sgt_out(sgt_out),
    .sle_out(sle_out),
    .sge_out(sge_out),
    .logical_32_out(logical_32_out),
    .mux_0_out(mux_0_out),
    .mux_1_out(mux_1_out),
    .mux_2_out(mux_2_out),
    .mux_3_out(mux_3_out),
    .mux_4_out(mux_4_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one op, clock it, then check the registered outputs.
  task automatic run(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e_out, input logic e_c,
                     input logic e_v);
    crtlSig = op;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    check({tag, ".out"}, out, e_out);
    check({tag, ".cout"}, {31'b0, cout}, {31'b0, e_c});
    check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, e_v});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    crtlSig = 4'b0000;
    in1 = 32'd5;
    in2 = 32'd7;

    repeat (2) @(posedge clk);
    #1;
    check("rst.out", out, 32'd0);
    check("rst.cout", {31'b0, cout}, 32'd0);
    check("rst.ovf", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    run("rel_add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

    run("seq11", 4'b0001, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
    run("sne11", 4'b1001, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    run("slt11", 4'b0101, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    run("sgt11", 4'b0011, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    run("sle11", 4'b1101, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
    run("sge11", 4'b1011, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
    run("add11", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

    run("slt_m1", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run("sgt_m1", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    run("sge_m1", 4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    run("slt_ov", 4'b0101, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    run("sgt_ov", 4'b0011, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    run("sne_d", 4'b1001, 32'd3, 32'd9, 32'd1, 1'b0, 1'b0);

    run("add_ov", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    run("add_c", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run("sub_ov", 4'b1000, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run("sub_neg", 4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("sub_eq", 4'b1000, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);

    run("ill0111", 4'b0111, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    run("ill0010", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    run("ill1111", 4'b1111, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    run("add_b2b", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);

    crtlSig = 4'b1101;
    in1 = 32'd3;
    in2 = 32'd5;
    #1;
`ifdef ALU_DEBUG_TAPS_EN
    check("tap.diff", diff, 32'hFFFF_FFFE);
    check("tap.adder", adder_out, 32'd8);
    check("tap.slt", slt_out, 32'd1);
    check("tap.mux1", mux_1_out, 32'd1);
    check("tap.log32", logical_32_out, 32'd1);
`else
    check("tap.diff", diff, 32'd0);
    check("tap.adder", adder_out, 32'd0);
    check("tap.cmps", seq_out | sne_out | slt_out | sgt_out | sle_out | sge_out,
          32'd0);
    check("tap.muxes", mux_0_out | mux_1_out | mux_2_out | mux_3_out |
          mux_4_out | logical_32_out, 32'd0);
`endif
    run("tap_sle", 4'b1101, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);

    rst_n = 1'b0;
    run("rst_ovr", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run("post_rst", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
